// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and constants for the UART TX frame arbiter.
//   arb_state_t : arbiter FSM states (ST_HEADER only exists when the
//                 UART_ARB_HEADER_EN macro is defined)
//   HDR_NIBBLE  : upper nibble of the channel-ID header byte
//   clog2_safe  : ceil(log2(n)) clamped to at least 1, for index widths
// ---------------------------------------------------------------------------
package uart_arb_pkg;

`ifdef UART_ARB_HEADER_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_STREAM = 2'd2
  } arb_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd2
  } arb_state_t;
`endif

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: picks the first set bit of req at or
// after ptr, wrapping modulo N_CH.
//   req    : request vector
//   ptr    : search start position (0..N_CH-1)
//   onehot : one-hot selection, zero when nothing requests
//   idx    : binary index of the selection
//   any    : at least one request is set
// ---------------------------------------------------------------------------
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  localparam int unsigned PW  = clog2_safe(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [N_CH-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);

  always_comb begin
    logic [PW-1:0] cand;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = PW'((32'(ptr) + k) % N_CH);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Frame-level round-robin arbiter sharing one UART transmitter between N_CH
// byte-stream channels. One channel is granted for a whole frame (until a
// byte with ch_last is accepted). A watchdog aborts a granted frame after
// TIMEOUT_CYC consecutive stream cycles without an accepted byte.
// Build option: define UART_ARB_HEADER_EN to prefix every frame with the
// header byte {4'hA, channel[3:0]}.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   ch_req       : per-channel frame pending (level)
//   ch_data      : packed bytes, channel i on [8i+7:8i]
//   ch_valid     : per-channel byte valid
//   ch_last      : byte is the final byte of its frame
//   ch_ready     : one-hot byte accept, combinational from tx_ready
//   ch_grant     : registered one-hot grant, zero when idle
//   tx_data      : byte to the UART
//   tx_valid     : tx_data valid, transfers when tx_ready is high
//   tx_ready     : UART can accept a byte
//   timeout_err  : one-cycle pulse on watchdog abort
//   busy         : arbiter not idle or a byte is still pending
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   ch_req,
  input  logic [N_CH*8-1:0] ch_data,
  input  logic [N_CH-1:0]   ch_valid,
  input  logic [N_CH-1:0]   ch_last,
  output logic [N_CH-1:0]   ch_ready,
  output logic [N_CH-1:0]   ch_grant,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              timeout_err,
  output logic              busy
);

  localparam int unsigned PW = clog2_safe(N_CH);
  localparam int unsigned WW = clog2_safe(TIMEOUT_CYC);

  arb_state_t        state_q, state_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic              tout_q, tout_d;

  logic [N_CH-1:0]   pick_oh;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;

  logic              out_free;
  logic              in_stream;
  logic              accept;
  logic              cur_valid;
  logic              cur_last;
  logic [7:0]        cur_byte;
  logic [PW-1:0]     next_ptr;

  rr_picker #(.N_CH(N_CH)) u_pick (
    .req    (ch_req),
    .ptr    (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Output register can take a new byte when empty or draining this cycle.
  assign out_free  = !tx_valid_q || tx_ready;
  assign in_stream = (state_q == ST_STREAM);

  // Grant is one-hot, so AND-OR muxing selects the granted channel.
  always_comb begin
    cur_byte = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant_q[i]) cur_byte = ch_data[i*8 +: 8];
    end
  end
  assign cur_valid = |(ch_valid & grant_q);
  assign cur_last  = |(ch_last & grant_q);
  assign accept    = in_stream && out_free && cur_valid;
  assign ch_ready  = (in_stream && out_free) ? grant_q : '0;
  assign next_ptr  = (gidx_q == PW'(N_CH - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    wd_d       = '0;
    tout_d     = 1'b0;

    if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_oh;
          gidx_d  = pick_idx;
`ifdef UART_ARB_HEADER_EN
          state_d = ST_HEADER;
`else
          state_d = ST_STREAM;
`endif
        end
      end
`ifdef UART_ARB_HEADER_EN
      ST_HEADER: begin
        if (out_free) begin
          tx_data_d  = {HDR_NIBBLE, 4'(gidx_q)};
          tx_valid_d = 1'b1;
          state_d    = ST_STREAM;
        end
      end
`endif
      ST_STREAM: begin
        if (accept) begin
          tx_data_d  = cur_byte;
          tx_valid_d = 1'b1;
          if (cur_last) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = ST_IDLE;
          end
        end else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
          // Abort: any byte already in tx_data still drains normally.
          tout_d   = 1'b1;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      wd_q       <= '0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      wd_q       <= wd_d;
      tout_q     <= tout_d;
    end
  end

  assign ch_grant    = grant_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign timeout_err = tout_q;
  assign busy        = (state_q != ST_IDLE) || tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Bench for uart_tx_arbiter (N_CH=4, TIMEOUT_CYC=8). Channel sources hold
// queued frames; the expected grant order and UART byte stream are derived
// from the round-robin rule over those frames.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int ML = 64;
`ifdef UART_ARB_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   ch_req, ch_valid, ch_last, ch_ready, ch_grant;
  logic [N*8-1:0] ch_data;
  logic [7:0]     tx_data;
  logic           tx_valid, tx_ready, timeout_err, busy;

  uart_tx_arbiter #(.N_CH(N), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .ch_req      (ch_req),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .ch_last     (ch_last),
    .ch_ready    (ch_ready),
    .ch_grant    (ch_grant),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-channel source memory: concatenated frames, last flag per byte.
  logic [7:0] mem [N][ML];
  logic       lst [N][ML];
  int         len [N];
  int         pos [N];
  logic [7:0] exp_q[$];
  int         ord_q[$];
  int         g_cyc, r_cyc, t_first, t_last;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ch_req   = '0;
    ch_valid = '0;
    ch_data  = '0;
    ch_last  = '0;
    tx_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ":grant"},    32'(ch_grant), 0);
    chk({tag, ":ready"},    32'(ch_ready), 0);
    chk({tag, ":tx_valid"}, 32'(tx_valid), 0);
    chk({tag, ":tx_data"},  32'(tx_data), 0);
    chk({tag, ":timeout"},  32'(timeout_err), 0);
    chk({tag, ":busy"},     32'(busy), 0);
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    exp_q.delete();
    ord_q.delete();
  endtask

  task automatic add_byte(input int ch, input logic [7:0] b, input logic l);
    mem[ch][len[ch]] = b;
    lst[ch][len[ch]] = l;
    len[ch]++;
  endtask

  task automatic add_rand_frame(input int ch, input int n);
    for (int k = 0; k < n; k++) add_byte(ch, 8'($urandom), k == n - 1);
  endtask

  // Serve whole frames: next channel is the first with a pending frame at
  // or after the pointer; the pointer then moves just past it.
  task automatic build_expect(input int ptr0);
    int fp [N];
    int p;
    int sel;
    p = ptr0;
    for (int i = 0; i < N; i++) fp[i] = 0;
    while (1) begin
      sel = -1;
      for (int k = 0; k < N; k++) begin
        if (sel < 0 && fp[(p + k) % N] < len[(p + k) % N]) sel = (p + k) % N;
      end
      if (sel < 0) break;
      ord_q.push_back(sel);
      if (HDR != 0) exp_q.push_back({4'hA, 4'(sel)});
      while (fp[sel] < len[sel]) begin
        exp_q.push_back(mem[sel][fp[sel]]);
        fp[sel]++;
        if (lst[sel][fp[sel] - 1]) break;
      end
      p = (sel + 1) % N;
    end
  endtask

  // mode 0: tx_ready/valid always high; 1: random with forced progress;
  // 2: tx_ready pattern 1,0,0,1.
  task automatic run_frames(input int mode, input int max_cyc);
    int         stall;
    int         cur;
    int         n_tx;
    int         n_gr;
    int         exp_tx;
    int         exp_gr;
    logic [N-1:0] prev_g;
    logic [N-1:0] exp_oh;
    logic [3:0] pat;
    bit         done;
    bit         frc;
    bit         acc;
    stall = 0; cur = -1; n_tx = 0; n_gr = 0; prev_g = '0; done = 0;
    pat = 4'b1001;
    exp_tx = exp_q.size();
    exp_gr = ord_q.size();
    g_cyc = -1; r_cyc = -1; t_first = -1; t_last = -1;
    for (int c = 0; c < max_cyc && !done; c++) begin
      frc = (stall >= 3);
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = frc || ($urandom_range(0, 3) != 0);
        default: tx_ready = pat[c % 4];
      endcase
      for (int i = 0; i < N; i++) begin
        if (pos[i] < len[i]) begin
          ch_req[i]        = 1'b1;
          ch_valid[i]      = (mode != 1) || frc || ($urandom_range(0, 3) != 0);
          ch_data[8*i +: 8] = mem[i][pos[i]];
          ch_last[i]       = lst[i][pos[i]];
        end else begin
          ch_req[i]        = 1'b0;
          ch_valid[i]      = 1'b0;
          ch_data[8*i +: 8] = '0;
          ch_last[i]       = 1'b0;
        end
      end
      #1;
      if (ch_grant != '0 && prev_g == '0) begin
        n_gr++;
        if (g_cyc < 0) g_cyc = c;
        if (ord_q.size() > 0) begin
          cur = ord_q.pop_front();
          chk("grant_order", 32'(ch_grant), 32'(1 << cur));
        end
      end
      if (ch_grant == '0) cur = -1;
      exp_oh = (cur >= 0) ? N'(1 << cur) : '0;
      chk("ready_owner", 32'(ch_ready & ~exp_oh), 0);
      if (tx_valid && !tx_ready) chk("ready_backpressure", 32'(ch_ready), 0);
      if (ch_ready != '0 && r_cyc < 0) r_cyc = c;
      if (tx_valid && tx_ready) begin
        n_tx++;
        if (t_first < 0) t_first = c;
        t_last = c;
        if (exp_q.size() > 0) chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      acc = 0;
      for (int i = 0; i < N; i++) begin
        if (ch_valid[i] && ch_ready[i]) begin
          pos[i]++;
          acc = 1;
        end
      end
      stall  = acc ? 0 : stall + 1;
      prev_g = ch_grant;
      done   = (exp_q.size() == 0) && (ord_q.size() == 0) && !busy;
      cyc();
    end
    chk("frames_done", 32'(done), 1);
    chk("tx_count", n_tx, exp_tx);
    chk("grant_count", n_gr, exp_gr);
    chk("end_grant", 32'(ch_grant), 0);
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit hit;
    bit drop;
    int bi;

    // Reset state
    do_reset();
    chk_quiet("reset");

    // Single frame on ch1: 11,22,33 with latency/throughput checks
    clear_src();
    add_byte(1, 8'h11, 1'b0);
    add_byte(1, 8'h22, 1'b0);
    add_byte(1, 8'h33, 1'b1);
    build_expect(0);
    run_frames(0, 100);
    chk("sf_grant_latency", g_cyc, 1);
    chk("sf_ready_latency", r_cyc, 1 + HDR);
    chk("sf_first_tx", t_first, 2);
    chk("sf_throughput", t_last - t_first, 2 + HDR);

    // Contention: ch0 and ch2 from reset, ch0 re-requests
    do_reset();
    clear_src();
    add_byte(0, 8'hC0, 1'b0);
    add_byte(0, 8'hC1, 1'b1);
    add_byte(0, 8'hC2, 1'b1);
    add_byte(2, 8'h20, 1'b0);
    add_byte(2, 8'h21, 1'b0);
    add_byte(2, 8'h22, 1'b1);
    build_expect(0);
    run_frames(0, 200);

    // Eight frames across all four channels
    do_reset();
    clear_src();
    for (int i = 0; i < N; i++) begin
      add_rand_frame(i, 2);
      add_rand_frame(i, 2);
    end
    build_expect(0);
    run_frames(0, 300);

    // Backpressure with tx_ready toggling 1,0,0,1
    do_reset();
    clear_src();
    add_rand_frame(1, 4);
    build_expect(0);
    run_frames(2, 200);

    // Randomized rounds
    for (int r = 0; r < 3; r++) begin
      do_reset();
      clear_src();
      for (int i = 0; i < N; i++) begin
        int nf;
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) add_rand_frame(i, $urandom_range(1, 5));
      end
      build_expect(0);
      run_frames(1, 3000);
    end

    // Watchdog: ch3 sends one byte then stalls; ch0 waits
    do_reset();
    ch_req   = 4'b1000;
    ch_valid = 4'b1000;
    ch_data[31:24] = 8'h5C;
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      #1;
      hit = ch_valid[3] && ch_ready[3];
      cyc();
    end
    chk("wd_accept", 32'(hit), 1);
    ch_req   = 4'b0001;
    ch_valid = 4'b0001;
    ch_last  = 4'b0001;
    ch_data  = '0;
    ch_data[7:0] = 8'h01;
    for (int k = 1; k <= 12; k++) begin
      #1;
      chk("wd_pulse", 32'(timeout_err), 32'(k == 9));
      if (k == 1) chk("wd_byte_kept", 32'(tx_data), 32'h5C);
      if (k == 5) chk("wd_grant_held", 32'(ch_grant), 32'b1000);
      if (k == 9) chk("wd_grant_clear", 32'(ch_grant), 0);
      if (k == 10) chk("wd_next_grant", 32'(ch_grant), 32'b0001);
      drop = ch_valid[0] && ch_ready[0];
      cyc();
      if (drop) begin
        ch_req   = '0;
        ch_valid = '0;
        ch_last  = '0;
      end
    end
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!busy) break;
      cyc();
    end
    chk("wd_idle", 32'(busy), 0);

    // Reset mid-frame: ch2 frame moves the pointer, then ch3 is cut by reset
    do_reset();
    ch_req   = 4'b0100;
    ch_valid = 4'b0100;
    ch_last  = 4'b0100;
    ch_data[23:16] = 8'h77;
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      #1;
      hit = ch_valid[2] && ch_ready[2];
      cyc();
    end
    chk("rst_pre_accept", 32'(hit), 1);
    drive_idle();
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!busy) break;
      cyc();
    end
    chk("rst_pre_idle", 32'(busy), 0);
    bi = 0;
    hit = 0;
    ch_req = 4'b1000;
    for (int k = 0; k < 20 && !hit; k++) begin
      ch_valid = 4'b1000;
      ch_data[31:24] = 8'(8'h30 + bi);
      ch_last = (bi == 3) ? 4'b1000 : 4'b0000;
      #1;
      if (ch_valid[3] && ch_ready[3]) begin
        if (bi == 1) begin
          reset = 1'b1;
          hit = 1;
        end
        bi++;
      end
      cyc();
    end
    chk("rst_hit", 32'(hit), 1);
    #1;
    chk_quiet("rst_mid");
    reset = 1'b0;
    drive_idle();
    ch_req = 4'b1001;
    cyc();
    #1;
    chk("rst_priority", 32'(ch_grant), 32'b0001);
    drive_idle();
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
